// File: rtl/writeback_unit_if.sv
// Bundle between the arithmetic/memory/operand-fetch stages and the writeback unit.
// The master modport drives requests and read addresses; the slave modport is the writeback unit.
interface writeback_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          resultValid_i;
  logic          wbEnable_i;
  logic [4:0]    wbAddress_i;
  logic [15:0]   wbData_i;
  logic [1:0]    statusWriteback_i;
  logic          loadValid_i;
  logic [4:0]    loadAddress_i;
  logic [15:0]   loadData_i;
  logic          clearStatus_i;
  logic [4:0]    rdAddrA_i;
  logic [4:0]    rdAddrB_i;
  logic [15:0]   rdDataA_o;
  logic [15:0]   rdDataB_o;
  logic          stall_o;
  logic [CW-1:0] count_o;
  logic [1:0]    statusReg_o;
  logic          dropError_o;

  modport master (
    output resultValid_i, wbEnable_i, wbAddress_i, wbData_i, statusWriteback_i,
    output loadValid_i, loadAddress_i, loadData_i, clearStatus_i,
    output rdAddrA_i, rdAddrB_i,
    input  rdDataA_o, rdDataB_o, stall_o, count_o, statusReg_o, dropError_o
  );

  modport slave (
    input  resultValid_i, wbEnable_i, wbAddress_i, wbData_i, statusWriteback_i,
    input  loadValid_i, loadAddress_i, loadData_i, clearStatus_i,
    input  rdAddrA_i, rdAddrB_i,
    output rdDataA_o, rdDataB_o, stall_o, count_o, statusReg_o, dropError_o
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: in-order result queue retiring into a 32x16 register file,
// with sticky status, a priority load-write port and two forwarded read ports.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input logic             clock_i,
  input logic             nReset_i,
  writeback_unit_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   rf     [32];
  logic          q_en   [DEPTH];
  logic [4:0]    q_addr [DEPTH];
  logic [15:0]   q_data [DEPTH];
  logic [1:0]    q_st   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [1:0]    status;
  logic          drop_err;

  logic          full;
  logic          retire;
  logic          enq;
  logic [PW-1:0] idx;
  logic [15:0]   fwd_a;
  logic [15:0]   fwd_b;

  // The load port owns the single regfile write port, so it blocks retirement.
  assign full   = (count == CW'(DEPTH));
  assign retire = (count != '0) && !wb.loadValid_i;
  assign enq    = wb.resultValid_i && (!full || retire);

  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      status   <= 2'b00;
      drop_err <= 1'b0;
    end else begin
      if (retire) head <= head + 1'b1;
      if (enq)    tail <= tail + 1'b1;
      case ({enq, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Clear first, then OR in the retiring status so set wins.
      status <= (wb.clearStatus_i ? 2'b00 : status) | (retire ? q_st[head] : 2'b00);
      if (wb.resultValid_i && !enq) drop_err <= 1'b1;
    end
  end

  // Queue payload needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clock_i) begin
    if (enq) begin
      q_en[tail]   <= wb.wbEnable_i;
      q_addr[tail] <= wb.wbAddress_i;
      q_data[tail] <= wb.wbData_i;
      q_st[tail]   <= wb.statusWriteback_i;
    end
  end

  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb.loadValid_i) begin
      rf[wb.loadAddress_i] <= wb.loadData_i;
    end else if (retire && q_en[head]) begin
      rf[q_addr[head]] <= q_data[head];
    end
  end

  // Walk live entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_a = rf[wb.rdAddrA_i];
    fwd_b = rf[wb.rdAddrB_i];
    idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && q_en[idx]) begin
        if (q_addr[idx] == wb.rdAddrA_i) fwd_a = q_data[idx];
        if (q_addr[idx] == wb.rdAddrB_i) fwd_b = q_data[idx];
      end
    end
  end

  assign wb.rdDataA_o   = fwd_a;
  assign wb.rdDataB_o   = fwd_b;
  assign wb.count_o     = count;
  assign wb.stall_o     = (count >= CW'(DEPTH - 1));
  assign wb.statusReg_o = status;
  assign wb.dropError_o = drop_err;
endmodule
